// File: rtl/mux_ser_pkg.sv
// Shared constants and state type for the 4-lane parallel-to-serial stage.
package mux_ser_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
endpackage

// File: rtl/lane_mux4.sv
// DATA_W-wide combinational 4:1 lane select out of a packed 4-lane word
// (lane a in the low bits, lane d in the high bits).
module lane_mux4 #(
  parameter int DATA_W = 1
) (
  input  logic [4*DATA_W-1:0] word_i,
  input  logic [1:0]          sel_i,
  output logic [DATA_W-1:0]   lane_o
);

  // pick one lane of the word
  always_comb begin
    lane_o = word_i[DATA_W-1:0];
    case (sel_i)
      2'd0: lane_o = word_i[DATA_W-1:0];
      2'd1: lane_o = word_i[2*DATA_W-1:DATA_W];
      2'd2: lane_o = word_i[3*DATA_W-1:2*DATA_W];
      2'd3: lane_o = word_i[4*DATA_W-1:3*DATA_W];
      default: lane_o = word_i[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/mux_serializer4.sv
// 4-lane parallel-to-serial stage: takes one word over valid/ready and emits
// lanes a,b,c,d one per accepted beat with a registered data output.
// Optional feature macro: SER_PARITY_EN adds out_par (even parity of the
// whole word, shown on the last beat only).
//
//  state | meaning
//  IDLE  | no word held, in_ready=1, out_valid=0
//  SHIFT | word held, out_data/out_sel show the current lane
module mux_serializer4
  import mux_ser_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_last
`ifdef SER_PARITY_EN
  ,
  output logic                out_par
`endif
);

  ser_state_t          state_q, state_d;
  logic [4*DATA_W-1:0] word_q, word_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                xfer;
  logic                last_xfer;
  logic                load;
  logic [4*DATA_W-1:0] mux_word;
  logic [SEL_W-1:0]    mux_sel;
  logic [DATA_W-1:0]   lane_nxt;

  assign out_valid = (state_q == SHIFT);
  assign out_last  = out_valid && (sel_q == 2'd3);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && out_last;
  assign in_ready  = (state_q == IDLE) || last_xfer;
  assign load      = in_valid && in_ready;

  // On a load the mux looks at the incoming word directly so lane a is
  // registered in the same edge that captures the word.
  assign mux_word = load ? in_data : word_q;
  assign mux_sel  = load ? 2'd0 : (sel_q + 2'd1);

  lane_mux4 #(.DATA_W(DATA_W)) u_lane_mux (
    .word_i (mux_word),
    .sel_i  (mux_sel),
    .lane_o (lane_nxt)
  );

  // next-state: load wins over the last-beat return to IDLE (back-to-back words)
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (load) begin
      state_d = SHIFT;
      word_d  = in_data;
      sel_d   = '0;
      data_d  = lane_nxt;
    end else if (last_xfer) begin
      state_d = IDLE;
      sel_d   = '0;
    end else if (xfer) begin
      sel_d  = sel_q + 2'd1;
      data_d = lane_nxt;
    end
  end

  // state, word, lane counter and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

`ifdef SER_PARITY_EN
  logic par_q;

  // parity of the whole word, captured once at load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^in_data;
    end
  end

  assign out_par = par_q && out_last;
`endif

endmodule
